// File: rtl/uart_hex_scan_driver.sv
// Buffers the latest NUM_BYTES UART bytes and scans them as hex nibbles onto a common-anode
// multi-digit display. Optional DISPLAY_BLANK_EN darkens digits not yet loaded since reset/clear.
module uart_hex_scan_driver #(
  parameter int unsigned NUM_BYTES = 2,
  parameter int unsigned SCAN_DIV  = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   clear,
  output logic [3:0]             hex_digit,
  output logic [2*NUM_BYTES-1:0] digit_sel,
  output logic                   digit_blank,
  output logic [7:0]             rx_count
);

  localparam int unsigned NumDigits = 2 * NUM_BYTES;
  localparam int unsigned BufW      = 8 * NUM_BYTES;
  localparam int unsigned IdxW      = $clog2(NumDigits);
  localparam int unsigned CntW      = $clog2(SCAN_DIV);

  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDigits - 1);

  logic [BufW-1:0]      buf_q, buf_d;
  logic [7:0]           rx_count_q, rx_count_d;
  logic [CntW-1:0]      scan_q, scan_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [3:0]           hex_q, hex_d;
  logic [NumDigits-1:0] sel_q, sel_d;
  logic                 blank_q, blank_d;

`ifdef DISPLAY_BLANK_EN
  localparam int unsigned FillW = $clog2(NUM_BYTES + 1);
  logic [FillW-1:0] fill_q, fill_d;
  localparam logic BlankRst = 1'b1;
`else
  localparam logic BlankRst = 1'b0;
`endif

  always_comb begin
    buf_d      = buf_q;
    rx_count_d = rx_count_q;
    if (clear) begin
      buf_d      = '0;
      rx_count_d = '0;
    end else if (rx_valid) begin
      buf_d      = (buf_q << 8) | BufW'(rx_data);
      rx_count_d = rx_count_q + 8'd1;
    end

    scan_d = scan_q + CntW'(1);
    idx_d  = idx_q;
    if (scan_q == ScanLast) begin
      scan_d = '0;
      idx_d  = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end

`ifdef DISPLAY_BLANK_EN
    fill_d = fill_q;
    if (clear) begin
      fill_d = '0;
    end else if (rx_valid && (int'(fill_q) != NUM_BYTES)) begin
      fill_d = fill_q + FillW'(1);
    end
    blank_d = (int'(idx_d) >= 2 * int'(fill_q));
`else
    blank_d = 1'b0;
`endif

    // Outputs follow the next index so digit_sel and hex_digit switch on the same edge.
    hex_d = buf_q[{idx_d, 2'b00} +: 4];
    sel_d = blank_d ? '1 : ~(NumDigits'(1) << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      rx_count_q <= '0;
      scan_q     <= '0;
      idx_q      <= '0;
      hex_q      <= 4'h0;
      sel_q      <= ~NumDigits'(1);
      blank_q    <= BlankRst;
`ifdef DISPLAY_BLANK_EN
      fill_q     <= '0;
`endif
    end else begin
      buf_q      <= buf_d;
      rx_count_q <= rx_count_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      hex_q      <= hex_d;
      sel_q      <= sel_d;
      blank_q    <= blank_d;
`ifdef DISPLAY_BLANK_EN
      fill_q     <= fill_d;
`endif
    end
  end

  assign hex_digit   = hex_q;
  assign digit_sel   = sel_q;
  assign digit_blank = blank_q;
  assign rx_count    = rx_count_q;

endmodule

// File: tb/tb_uart_hex_scan_driver.sv
// Scoreboard bench for uart_hex_scan_driver: a byte-history model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_uart_hex_scan_driver;

  localparam int NB = 2;
  localparam int SD = 4;
  localparam int ND = 2 * NB;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          clear;
  logic [3:0]    hex_digit;
  logic [ND-1:0] digit_sel;
  logic          digit_blank;
  logic [7:0]    rx_count;

  uart_hex_scan_driver #(
    .NUM_BYTES(NB),
    .SCAN_DIV (SD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .clear      (clear),
    .hex_digit  (hex_digit),
    .digit_sel  (digit_sel),
    .digit_blank(digit_blank),
    .rx_count   (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    hex;
    logic [ND-1:0] sel;
    logic          blank;
    logic [7:0]    cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state: received bytes (newest last), accepted count, edges since reset release.
  byte unsigned hist[$];
  int unsigned  cnt_m   = 0;
  int unsigned  ticks   = 0;
  int unsigned  old_val = 0;
`ifdef DISPLAY_BLANK_EN
  int           old_fill = 0;
`endif

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic int unsigned buf_val();
    int unsigned v = 0;
    for (int j = 0; j < hist.size(); j++) v |= int'(hist[hist.size() - 1 - j]) << (8 * j);
    return v;
  endfunction

  task automatic push_exp();
    exp_t e;
    int   idx = (ticks / SD) % ND;
    e.hex = 4'((old_val >> (4 * idx)) & 32'hF);
`ifdef DISPLAY_BLANK_EN
    e.blank = (idx >= 2 * old_fill);
`else
    e.blank = 1'b0;
`endif
    e.sel = e.blank ? {ND{1'b1}} : ~(ND'(1) << idx);
    e.cnt = 8'(cnt_m);
    exp_q.push_back(e);
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e.hex = 4'h0;
    e.sel = ~ND'(1);
`ifdef DISPLAY_BLANK_EN
    e.blank = 1'b1;
`else
    e.blank = 1'b0;
`endif
    e.cnt = 8'h00;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge: drive inputs, let the next edge take them, predict.
  task automatic step(input bit v, input byte unsigned d, input bit c);
    rx_valid = v;
    rx_data  = d;
    clear    = c;
    @(posedge clk);
    old_val = buf_val();
`ifdef DISPLAY_BLANK_EN
    old_fill = hist.size();
`endif
    if (c) begin
      hist.delete();
      cnt_m = 0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > NB) void'(hist.pop_front());
      cnt_m = (cnt_m + 1) % 256;
    end
    ticks++;
    push_exp();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Reset lands mid-cycle so the same-cycle negedge sample proves it is asynchronous.
  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    clear    = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    hist.delete();
    cnt_m   = 0;
    ticks   = 0;
    old_val = 0;
`ifdef DISPLAY_BLANK_EN
    old_fill = 0;
`endif
    push_reset_exp();
    repeat (2) begin
      @(posedge clk);
      push_reset_exp();
    end
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("hex_digit", hex_digit, e.hex);
      chk("digit_sel", digit_sel, e.sel);
      chk("digit_blank", digit_blank, e.blank);
      chk("rx_count", rx_count, e.cnt);
    end
  end

  initial begin
    int guard;
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    clear    = 1'b0;

    do_reset();
    idle(20);

    step(1'b1, 8'h3C, 1'b0);
    idle(3);
    step(1'b1, 8'hA5, 1'b0);
    idle(20);

    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    idle(20);

    step(1'b1, 8'hAB, 1'b0);
    idle(2);
    step(1'b1, 8'h77, 1'b1);
    idle(20);

    // rx_count wrap 255 -> 0 with back-to-back accepts
    step(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 260; k++) step(1'b1, 8'($urandom), 1'b0);
    idle(4);

    for (int k = 0; k < 400; k++) begin
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % 40) == 0);
    end
    idle(4);

    // Reset mid-dwell on digit 2 with 0xBEEF loaded
    step(1'b1, 8'hBE, 1'b0);
    step(1'b1, 8'hEF, 1'b0);
    guard = 0;
    while (!(((ticks / SD) % ND) == 2 && (ticks % SD) == 1) && guard < 100) begin
      idle(1);
      guard++;
    end
    chk("reach_digit2_bound", guard < 100, 1);
    do_reset();
    idle(20);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
